// File: rtl/lzrw1_stream_decompressor.sv
// LZRW1 stream decompressor: turns literal/copy items into a byte stream
// through a registered valid/ready output. Keeps a power-of-two history
// window that is flushed at block boundaries, and raises a sticky flag on
// copy items that are malformed or reach outside the current block.
module lzrw1_stream_decompressor #(
   parameter int HISTORY_SIZE = 4096,
   parameter int HIST_AW      = $clog2(HISTORY_SIZE)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [15:0]       data_in,
   input  logic              control_word_in,
   input  logic              data_in_valid,
   input  logic              data_in_last,
   output logic              data_in_ready,
   output logic [7:0]        decompressed_byte,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              protocol_error,
   output logic [HIST_AW:0]  history_fill
);

   localparam logic [0:0]       IDLE     = 1'b0;
   localparam logic [0:0]       COPY     = 1'b1;
   localparam logic [HIST_AW:0] FILL_MAX = (HIST_AW+1)'(HISTORY_SIZE);

   logic [0:0]         state;
   logic [HIST_AW-1:0] wr_ptr;
   logic [HIST_AW-1:0] src_ptr;
   logic [3:0]         remaining;
   logic               last_pending;
   logic [7:0]         history [HISTORY_SIZE];

   logic               out_free;
   logic               accept;
   logic               copy_legal;
   logic               load_lit;
   logic               load_first;
   logic               load_next;
   logic               load;
   logic               load_last;
   logic               illegal;
   logic [3:0]         len_code;
   logic [11:0]        offset;
   logic [12:0]        offset_ext;
   logic [12:0]        fill_ext;
   logic [HIST_AW-1:0] first_src;
   logic [HIST_AW-1:0] rd_addr;
   logic [7:0]         load_byte;

   // Fill level grows by one per stored byte and pins at the window size.
   function automatic logic [HIST_AW:0] sat_inc(input logic [HIST_AW:0] v);
      return (v == FILL_MAX) ? v : v + 1'b1;
   endfunction

   // Input gating is combinational so an item can enter as the previous byte leaves.
   assign out_free      = !out_valid || out_ready;
   assign data_in_ready = (state == IDLE) && out_free && !reset;
   assign accept        = data_in_valid && data_in_ready;

   // Item decode, copy legality and selection of the byte loaded this cycle.
   always_comb begin
      len_code   = data_in[15:12];
      offset     = data_in[11:0];
      offset_ext = {1'b0, offset};
      fill_ext   = 13'(history_fill);
      copy_legal = (len_code >= 4'd2) && (offset != 12'd0) && (offset_ext <= fill_ext);
      first_src  = wr_ptr - offset[HIST_AW-1:0];
      load_lit   = accept && !control_word_in;
      load_first = accept && control_word_in && copy_legal;
      illegal    = accept && control_word_in && !copy_legal;
      load_next  = (state == COPY) && out_free;
      load       = load_lit || load_first || load_next;
      rd_addr    = (state == COPY) ? src_ptr : first_src;
      load_byte  = load_lit ? data_in[7:0] : history[rd_addr];
      load_last  = 1'b0;
      if (load_lit) begin
         load_last = data_in_last;
      end else if (load_next) begin
         load_last = last_pending && (remaining == 4'd1);
      end
   end

   // Control: copy sequencing, write pointer, fill level and sticky error flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         src_ptr        <= '0;
         remaining      <= 4'd0;
         last_pending   <= 1'b0;
         wr_ptr         <= '0;
         history_fill   <= '0;
         protocol_error <= 1'b0;
      end else begin
         if (load_first) begin
            state        <= COPY;
            src_ptr      <= first_src + 1'b1;
            remaining    <= len_code;
            last_pending <= data_in_last;
         end else if (load_next) begin
            src_ptr   <= src_ptr + 1'b1;
            remaining <= remaining - 4'd1;
            if (remaining == 4'd1) begin
               state <= IDLE;
            end
         end
         if (load) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if ((load && load_last) || (illegal && data_in_last)) begin
            history_fill <= '0;
         end else if (load) begin
            history_fill <= sat_inc(history_fill);
         end
         if (illegal) begin
            protocol_error <= 1'b1;
         end
      end
   end

   // Output register: loads a new byte or drains when the consumer takes it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         decompressed_byte <= 8'd0;
         out_valid         <= 1'b0;
         out_last          <= 1'b0;
      end else if (load) begin
         decompressed_byte <= load_byte;
         out_valid         <= 1'b1;
         out_last          <= load_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

   // History write: every emitted byte is stored; overlapping copies read it back next cycle.
   always_ff @(posedge clock) begin
      if (load) begin
         history[wr_ptr] <= load_byte;
      end
   end

endmodule

// File: tb/tb_lzrw1_stream_decompressor.sv
// Bench for lzrw1_stream_decompressor with a 16-byte window: table of items
// with hand-derived fill/error levels, directed timing and reset sequences,
// and a randomized run scored against a queue-based LZRW1 model.
module tb_lzrw1_stream_decompressor;

   localparam int HS = 16;
   localparam int AW = $clog2(HS);

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] data_in = 16'd0;
   logic        control_word_in = 1'b0;
   logic        data_in_valid = 1'b0;
   logic        data_in_last = 1'b0;
   logic        data_in_ready;
   logic [7:0]  decompressed_byte;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_last;
   logic        protocol_error;
   logic [AW:0] history_fill;

   lzrw1_stream_decompressor #(.HISTORY_SIZE(HS)) dut (
      .clock             (clock),
      .reset             (reset),
      .data_in           (data_in),
      .control_word_in   (control_word_in),
      .data_in_valid     (data_in_valid),
      .data_in_last      (data_in_last),
      .data_in_ready     (data_in_ready),
      .decompressed_byte (decompressed_byte),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_last          (out_last),
      .protocol_error    (protocol_error),
      .history_fill      (history_fill)
   );

   always #5 clock = ~clock;

   int         checks = 0;
   int         errors = 0;
   int         rdy_mode = 0;
   int         w;
   logic [8:0] exp_q[$];
   logic [7:0] blk[$];
   logic       exp_err = 1'b0;
   logic       hold_prev = 1'b0;
   logic [7:0] byte_prev = 8'd0;
   logic [15:0] ill [3];

   typedef struct {
      logic        cw;
      logic [15:0] d;
      logic        last;
      int          fill;
      int          err;
   } vec_t;
   vec_t tbl [12];

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference model: the current block as a plain byte list, at most HS long.
   function automatic void model_accept(input logic cw, input logic [15:0] d, input logic last);
      int len;
      int off;
      logic [7:0] b;
      if (!cw) begin
         blk.push_back(d[7:0]);
         exp_q.push_back({last, d[7:0]});
      end else begin
         len = int'(d[15:12]) + 1;
         off = int'(d[11:0]);
         if (len < 3 || off == 0 || off > blk.size()) begin
            exp_err = 1'b1;
         end else begin
            for (int i = 0; i < len; i++) begin
               b = blk[blk.size() - off];
               blk.push_back(b);
               exp_q.push_back({last && (i == len - 1), b});
            end
         end
      end
      if (last) blk.delete();
      while (blk.size() > HS) void'(blk.pop_front());
   endfunction

   // Ready pattern for the consumer side.
   always @(posedge clock) begin
      #1;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   // Output scoreboard and hold-stability monitor.
   always @(negedge clock) begin
      logic [8:0] e;
      if (reset) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_byte", int'(decompressed_byte), int'(byte_prev));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte actual=%0d required=none", decompressed_byte);
            end else begin
               e = exp_q.pop_front();
               check("out_byte", int'(decompressed_byte), int'(e[7:0]));
               check("out_last", int'(out_last), int'(e[8]));
            end
         end
         hold_prev = out_valid && !out_ready;
         byte_prev = decompressed_byte;
      end
   end

   task automatic send(input logic cw, input logic [15:0] d, input logic last, output int waits);
      waits = 0;
      control_word_in = cw;
      data_in         = d;
      data_in_last    = last;
      data_in_valid   = 1'b1;
      @(negedge clock);
      while (!data_in_ready && waits < 300) begin
         waits++;
         @(negedge clock);
      end
      if (!data_in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout actual=stalled required=accepted");
      end else begin
         model_accept(cw, d, last);
      end
      @(posedge clock);
      #1;
      data_in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clock);
      while (!(exp_q.size() == 0 && !out_valid && data_in_ready) && n < 500) begin
         n++;
         @(negedge clock);
      end
      if (n >= 500) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout pending=%0d required=0", exp_q.size());
      end
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      data_in_valid = 1'b0;
      reset = 1'b1;
      #1;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_byte", int'(decompressed_byte), 0);
      check("rst_out_last", int'(out_last), 0);
      check("rst_error", int'(protocol_error), 0);
      check("rst_fill", int'(history_fill), 0);
      check("rst_ready", int'(data_in_ready), 0);
      exp_q.delete();
      blk.delete();
      exp_err = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] code;
      int         off;
      int         r;
      logic       last;

      tbl[0]  = '{1'b0, 16'h0061, 1'b0, 1, 0};
      tbl[1]  = '{1'b0, 16'h0062, 1'b0, 2, 0};
      tbl[2]  = '{1'b0, 16'h0063, 1'b1, 0, 0};
      tbl[3]  = '{1'b1, 16'h2001, 1'b0, 0, 1};
      tbl[4]  = '{1'b0, 16'h0061, 1'b0, 1, 1};
      tbl[5]  = '{1'b0, 16'h0062, 1'b0, 2, 1};
      tbl[6]  = '{1'b1, 16'h5002, 1'b0, 8, 1};
      tbl[7]  = '{1'b0, 16'h007A, 1'b0, 9, 1};
      tbl[8]  = '{1'b1, 16'hF001, 1'b0, 16, 1};
      tbl[9]  = '{1'b1, 16'h2010, 1'b0, 16, 1};
      tbl[10] = '{1'b1, 16'h2014, 1'b0, 16, 1};
      tbl[11] = '{1'b1, 16'h2010, 1'b1, 0, 1};
      ill[0] = 16'h2000;
      ill[1] = 16'h2005;
      ill[2] = 16'h1001;

      @(posedge clock);
      #1;

      // Table of items with hand-derived fill and error levels.
      do_reset();
      rdy_mode = 0;
      for (int i = 0; i < 12; i++) begin
         send(tbl[i].cw, tbl[i].d, tbl[i].last, w);
         wait_idle();
         check("tbl_fill", int'(history_fill), tbl[i].fill);
         check("tbl_error", int'(protocol_error), tbl[i].err);
      end

      // Latency and throughput of literals and an overlapping copy.
      do_reset();
      rdy_mode = 0;
      send(1'b0, 16'h0061, 1'b0, w);
      check("lit_latency_valid", int'(out_valid), 1);
      check("lit_latency_byte", int'(decompressed_byte), 8'h61);
      send(1'b0, 16'h0062, 1'b0, w);
      check("lit_b2b_wait", w, 0);
      send(1'b0, 16'h0063, 1'b0, w);
      check("lit_b2b_wait", w, 0);
      send(1'b1, 16'h5002, 1'b0, w);
      check("copy_accept_wait", w, 0);
      check("copy_first_byte", int'(decompressed_byte), 8'h62);
      send(1'b0, 16'h0064, 1'b0, w);
      check("copy_busy_cycles", w, 5);
      wait_idle();
      check("timing_fill", int'(history_fill), 10);

      // Each illegal copy from a fresh start: no output, sticky error.
      for (int k = 0; k < 3; k++) begin
         do_reset();
         rdy_mode = 0;
         send(1'b0, 16'h0061, 1'b0, w);
         send(1'b0, 16'h0062, 1'b0, w);
         send(1'b0, 16'h0063, 1'b0, w);
         wait_idle();
         send(1'b1, ill[k], 1'b0, w);
         wait_idle();
         check("illegal_error", int'(protocol_error), 1);
         check("illegal_fill", int'(history_fill), 3);
         send(1'b0, 16'h0064, 1'b0, w);
         wait_idle();
         check("illegal_sticky", int'(protocol_error), 1);
         check("illegal_then_lit_fill", int'(history_fill), 4);
      end

      // Run of 16 copied bytes under toggling backpressure.
      do_reset();
      rdy_mode = 1;
      send(1'b0, 16'h0078, 1'b0, w);
      send(1'b1, 16'hF001, 1'b0, w);
      wait_idle();
      check("toggle_fill", int'(history_fill), HS);
      check("toggle_error", int'(protocol_error), 0);
      rdy_mode = 0;

      // Saturation, full-window copy across the wrap, and reset mid-copy.
      do_reset();
      for (int i = 0; i < 20; i++) send(1'b0, 16'(i), 1'b0, w);
      wait_idle();
      check("fill_saturated", int'(history_fill), HS);
      send(1'b1, 16'h2010, 1'b0, w);
      check("wrap_copy_b0", int'(decompressed_byte), 8'h04);
      @(posedge clock);
      #1;
      check("wrap_copy_b1", int'(decompressed_byte), 8'h05);
      @(posedge clock);
      #1;
      check("wrap_copy_b2", int'(decompressed_byte), 8'h06);
      wait_idle();
      send(1'b1, 16'hF001, 1'b0, w);
      repeat (3) @(posedge clock);
      #1;
      do_reset();
      @(negedge clock);
      check("post_rst_ready", int'(data_in_ready), 1);
      check("post_rst_fill", int'(history_fill), 0);
      check("post_rst_valid", int'(out_valid), 0);
      @(posedge clock);
      #1;
      send(1'b0, 16'h006B, 1'b0, w);
      wait_idle();
      check("post_rst_lit_fill", int'(history_fill), 1);

      // Randomized items against the reference model.
      do_reset();
      rdy_mode = 2;
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         last = ($urandom_range(0, 15) == 0);
         if (blk.size() == 0 || r < 35) begin
            send(1'b0, 16'($urandom), last, w);
         end else begin
            code = 4'($urandom_range(2, 15));
            off  = $urandom_range(1, blk.size());
            if (r >= 97) off = blk.size() + 1;
            else if (r >= 95) code = 4'($urandom_range(0, 1));
            send(1'b1, {code, 12'(off)}, last, w);
         end
      end
      wait_idle();
      check("rand_error", int'(protocol_error), int'(exp_err));
      check("rand_fill", int'(history_fill), blk.size());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lzrw1_stream_decompressor.md
Name: lzrw1_stream_decompressor

Overview:
- Parametrised successor to decompressor_top, the LZRW1 decompression core.
- Consumes one 16-bit item per handshake, tagged by a control bit: literal or copy.
- Emits one decompressed byte per cycle through a valid/ready output with full backpressure.
- Adds: configurable history depth, per-block history flush with end-of-block marking, and sticky detection of illegal copy items.

Parameters:
- HISTORY_SIZE, 4096: history buffer depth in bytes; power of two, 16..4096.
- HIST_AW, $clog2(HISTORY_SIZE): history address width; derived, not overridden.

Ports:
- clock, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-high reset.
- data_in, in, 16: item.
  - Literal: byte is in [7:0].
  - Copy: length code in [15:12], offset in [11:0].
- control_word_in, in, 1: 0 = literal, 1 = copy.
- data_in_valid, in, 1: item present.
- data_in_last, in, 1: item is the final item of a compressed block.
- data_in_ready, out, 1: item accepted when valid and ready are both high.
- decompressed_byte, out, 8: output byte (registered).
- out_valid, out, 1: decompressed_byte is valid.
- out_ready, in, 1: downstream accepts the byte.
- out_last, out, 1: the byte is the final byte of its block.
- protocol_error, out, 1: sticky illegal-item flag.
- history_fill, out, HIST_AW+1: valid bytes in history; saturates at HISTORY_SIZE.

Behaviour:
- Reset: asynchronous, active-high, applied at any time.
  - Outputs: out_valid=0, decompressed_byte=0, out_last=0, protocol_error=0, history_fill=0, data_in_ready=0 while reset is high.
  - Internal: wr_ptr=0, state=IDLE.
  - History RAM contents are don't-care.
  - Reset mid-copy abandons the copy; the pending output byte is discarded.
- Output register is free when: !out_valid || out_ready.
- States: IDLE, COPY.
- data_in_ready = (state==IDLE) && output register free.
- History memory: asynchronous read, synchronous write.
  - Every byte loaded into the output register is written to history[wr_ptr] in the same cycle.
  - wr_ptr increments modulo HISTORY_SIZE.
  - history_fill increments, saturating at HISTORY_SIZE.
- Literal accepted in IDLE:
  - decompressed_byte <= data_in[7:0], out_valid <= 1, next cycle.
  - Latency is 1 cycle; state stays IDLE.
- Copy item: length L = data_in[15:12] + 1, range 3..16. Offset = data_in[11:0].
- Copy legality: length code >= 2 and 1 <= offset <= history_fill.
- Legal copy accepted:
  - src = wr_ptr - offset (mod HISTORY_SIZE).
  - Byte 0 = history[src] is loaded in the accept cycle.
  - State -> COPY with remaining = L-1.
  - Each COPY cycle with the output register free: load history[src+1...], write it to history, decrement remaining.
  - Return to IDLE after the last byte is loaded.
  - Stall, holding all state, while the output register is not free.
- Overlapping copies (offset < L) replicate bytes correctly. Example: offset=1 repeats the last byte. This relies on the read observing writes from earlier cycles; no forwarding path is needed.
- Throughput: an item of length N (literal N=1) occupies exactly N cycles with out_ready held high. The next item can be accepted in the cycle after its last byte is loaded.
- Illegal copy:
  - The item is accepted (handshake completes) and produces no output.
  - protocol_error <= 1 and stays set until reset.
  - History and fill are unchanged.
  - If data_in_last=1 on the illegal item, the block-end flush still occurs.
- data_in_last:
  - Latched with the item.
  - out_last=1 on that item's final output byte only.
  - In the cycle that byte loads, history_fill <= 0; the write still occurs and wr_ptr continues.
  - Offsets in the next block cannot reference the previous block.
- Simultaneous out_ready and load: the old byte leaves and the new byte loads in the same cycle, with no bubble.
- history_fill reaches HISTORY_SIZE and holds; offset == HISTORY_SIZE is legal when fill is saturated (src == wr_ptr).
- Offsets > HISTORY_SIZE are always illegal. Example: HISTORY_SIZE=256, offset 300.

Test Plan:
- Literals 'a','b','c', out_ready=1 -> "abc" on three consecutive cycles; first byte 1 cycle after accept; history_fill=3.
- Literals "ab" + copy len code 5 (L=6), offset 2 -> "ababab" back-to-back, 6 cycles; data_in_ready low for 5 cycles; total "abababab".
- Literal 'x' + copy L=16, offset 1 -> 16 bytes of 'x'.
  - Also: toggle out_ready 0/1 every cycle -> no byte lost or duplicated; decompressed_byte stable while out_valid && !out_ready.
- Illegal items, each -> protocol_error=1 and no output:
  - offset 0;
  - offset 5 with history_fill=3;
  - length code 1.
  - Then a legal literal still decodes; protocol_error stays 1 until reset.
- Block "abc" with data_in_last on 'c' -> out_last only on 'c'; history_fill=0 after.
  - Then copy offset 1 -> protocol_error=1.
- HISTORY_SIZE=16:
  - Feed 20 literals 0x00..0x13 -> history_fill saturates at 16.
  - Copy L=3, offset 16 -> 0x04,0x05,0x06.
  - Assert reset mid-copy -> out_valid=0 immediately; after release, data_in_ready returns and history_fill=0.
